// File: rtl/prog_accum_engine_if.sv
// Load/execute control and status bundle for prog_accum_engine.
// master drives mode and the instruction stream; slave returns result and status.
interface prog_accum_engine_if #(
  parameter int DATA_W = 10,
  parameter int VAL_W  = 4,
  parameter int DEPTH  = 32
) ();
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic              mode;
  logic              op_valid;
  logic [2:0]        opCode;
  logic [VAL_W-1:0]  value;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] prev_result;
  logic [CW-1:0]     cache_count;
  logic [IW-1:0]     exec_index;
  logic              cacheFull;
  logic              invalidOp;
  logic              overflow;

  modport master (
    output mode, op_valid, opCode, value,
    input  result, prev_result, cache_count, exec_index, cacheFull, invalidOp, overflow
  );

  modport slave (
    input  mode, op_valid, opCode, value,
    output result, prev_result, cache_count, exec_index, cacheFull, invalidOp, overflow
  );
endinterface

// File: rtl/prog_accum_engine.sv
// Programmable accumulator: caches opcode/operand pairs, then replays one per clock in a loop.
// Latency 1 clock to result/overflow; no backpressure, one load or one execute per clock.
module prog_accum_engine #(
  parameter int DATA_W   = 10,
  parameter int VAL_W    = 4,
  parameter int DEPTH    = 32,
  parameter int SATURATE = 0
) (
  input logic                clk,
  input logic                reset,
  prog_accum_engine_if.slave bus
);
  localparam int IW   = $clog2(DEPTH);
  localparam int CW   = IW + 1;
  localparam int PW   = 2 * DATA_W + 1;
  localparam int CMPW = (VAL_W > CW) ? VAL_W : CW;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADD2 = 3'b001,
    OP_FMA  = 3'b010,
    OP_POPC = 3'b100,
    OP_BREW = 3'b101,
    OP_SETR = 3'b110
  } op_e;

  logic [2:0]       op_mem  [DEPTH];
  logic [VAL_W-1:0] val_mem [DEPTH];

  logic [DATA_W-1:0] result_q, prev_q;
  logic [CW-1:0]     count_q;
  logic [IW-1:0]     idx_q;
  logic [VAL_W-1:0]  restart_q;
  logic              inv_q, ovf_q, full_q;

  op_e               cur_op;
  logic [VAL_W-1:0]  cur_val;
  logic [PW-1:0]     wide;
  logic              arith, ovf_nxt;
  logic [DATA_W-1:0] res_nxt;
  logic [VAL_W-1:0]  restart_nxt;
  logic [CW-1:0]     inc;
  logic [IW-1:0]     idx_nxt;
  logic              illegal, is_full, load_go, exec_go;
  logic [CW-1:0]     count_nxt;

  assign illegal   = (bus.opCode[1:0] == 2'b11);
  assign is_full   = (count_q == CW'(DEPTH));
  assign load_go   = !bus.mode && bus.op_valid && !illegal && !is_full;
  assign exec_go   = bus.mode && (count_q != '0);
  assign count_nxt = load_go ? count_q + CW'(1) : count_q;

  always_comb begin
    cur_op      = op_e'(op_mem[idx_q]);
    cur_val     = val_mem[idx_q];
    wide        = PW'(result_q);
    arith       = 1'b0;
    restart_nxt = restart_q;
    case (cur_op)
      OP_ADD:  begin wide = PW'(result_q) + PW'(cur_val); arith = 1'b1; end
      OP_ADD2: begin wide = PW'(result_q) + PW'(prev_q) + PW'(cur_val); arith = 1'b1; end
      OP_FMA:  begin wide = PW'(result_q) * PW'(prev_q) + PW'(cur_val); arith = 1'b1; end
      OP_POPC: wide = PW'($countones(result_q));
      OP_BREW: wide = PW'(~result_q);
      OP_SETR: restart_nxt = cur_val;
      default: wide = PW'(result_q);
    endcase
    ovf_nxt = arith && (wide[PW-1:DATA_W] != '0);
    res_nxt = (ovf_nxt && SATURATE != 0) ? {DATA_W{1'b1}} : wide[DATA_W-1:0];

    // A restart index outside the loaded program falls back to entry 0.
    inc     = CW'(idx_q) + CW'(1);
    idx_nxt = inc[IW-1:0];
    if (inc == count_q)
      idx_nxt = (CMPW'(restart_nxt) < CMPW'(count_q)) ? IW'(restart_nxt) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q  <= '0;
      prev_q    <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      restart_q <= '0;
      inv_q     <= 1'b0;
      ovf_q     <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      inv_q   <= !bus.mode && bus.op_valid && illegal;
      count_q <= count_nxt;
      full_q  <= (count_nxt == CW'(DEPTH));
      if (exec_go) begin
        prev_q    <= result_q;
        result_q  <= res_nxt;
        ovf_q     <= ovf_nxt;
        restart_q <= restart_nxt;
        idx_q     <= idx_nxt;
      end
    end
  end

  // Program storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (load_go) begin
      op_mem[count_q[IW-1:0]]  <= bus.opCode;
      val_mem[count_q[IW-1:0]] <= bus.value;
    end
  end

  assign bus.result      = result_q;
  assign bus.prev_result = prev_q;
  assign bus.cache_count = count_q;
  assign bus.exec_index  = idx_q;
  assign bus.cacheFull   = full_q;
  assign bus.invalidOp   = inv_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_prog_accum_engine.sv
// Directed bench for prog_accum_engine (DATA_W=10, VAL_W=4, DEPTH=32, wrapping arithmetic).
module tb_prog_accum_engine;
  logic clk;
  logic reset;
  int   vectors;
  int   errs;

  prog_accum_engine_if #(.DATA_W(10), .VAL_W(4), .DEPTH(32)) bus ();

  prog_accum_engine #(.DATA_W(10), .VAL_W(4), .DEPTH(32), .SATURATE(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [2:0] op, input logic [3:0] v);
    bus.mode     = 1'b0;
    bus.op_valid = 1'b1;
    bus.opCode   = op;
    bus.value    = v;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic exec1();
    bus.mode = 1'b1;
    @(posedge clk);
    #1;
    bus.mode = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int exp_r[4];
    int exp_p[4];
    int exp5[6];
    vectors      = 0;
    errs         = 0;
    clk          = 1'b0;
    reset        = 1'b1;
    bus.mode     = 1'b0;
    bus.op_valid = 1'b0;
    bus.opCode   = 3'b000;
    bus.value    = 4'd0;
    #1;
    check("rst_result", 32'(bus.result), 0);
    check("rst_prev", 32'(bus.prev_result), 0);
    check("rst_count", 32'(bus.cache_count), 0);
    check("rst_index", 32'(bus.exec_index), 0);
    check("rst_full", 32'(bus.cacheFull), 0);
    check("rst_invalid", 32'(bus.invalidOp), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Two ADDs looping
    load(3'b000, 4'd3);
    load(3'b000, 4'd4);
    check("t1_count", 32'(bus.cache_count), 2);
    exp_r = '{3, 7, 10, 14};
    exp_p = '{0, 3, 7, 10};
    for (int i = 0; i < 4; i++) begin
      exec1();
      check($sformatf("t1_result%0d", i), 32'(bus.result), exp_r[i]);
      check($sformatf("t1_prev%0d", i), 32'(bus.prev_result), exp_p[i]);
    end

    // Illegal opcode is flagged for one cycle and not stored
    do_reset();
    load(3'b011, 4'd1);
    check("t2_invalid_hi", 32'(bus.invalidOp), 1);
    check("t2_count", 32'(bus.cache_count), 0);
    @(posedge clk);
    #1;
    check("t2_invalid_lo", 32'(bus.invalidOp), 0);
    load(3'b111, 4'd2);
    check("t2_invalid_111", 32'(bus.invalidOp), 1);

    // Fill the cache; the 33rd op is dropped
    do_reset();
    for (int i = 0; i < 31; i++) load(3'b000, 4'(i));
    check("t3_full_31", 32'(bus.cacheFull), 0);
    check("t3_count_31", 32'(bus.cache_count), 31);
    load(3'b000, 4'd5);
    check("t3_full_32", 32'(bus.cacheFull), 1);
    check("t3_count_32", 32'(bus.cache_count), 32);
    load(3'b000, 4'd6);
    check("t3_full_33", 32'(bus.cacheFull), 1);
    check("t3_count_33", 32'(bus.cache_count), 32);
    check("t3_invalid", 32'(bus.invalidOp), 0);

    // Wrap on arithmetic overflow
    do_reset();
    load(3'b000, 4'd15);
    for (int i = 0; i < 68; i++) exec1();
    check("t4_pre_result", 32'(bus.result), 1020);
    check("t4_pre_ovf", 32'(bus.overflow), 0);
    exec1();
    check("t4_result", 32'(bus.result), 11);
    check("t4_ovf", 32'(bus.overflow), 1);
    check("t4_prev", 32'(bus.prev_result), 1020);
    exec1();
    check("t4_after_result", 32'(bus.result), 26);
    check("t4_after_ovf", 32'(bus.overflow), 0);

    // Loop restarts at the SETR entry, so SETR itself re-executes and holds the result
    do_reset();
    load(3'b000, 4'd1);
    load(3'b110, 4'd1);
    load(3'b000, 4'd2);
    exp5 = '{1, 1, 3, 3, 5, 5};
    for (int i = 0; i < 6; i++) begin
      exec1();
      check($sformatf("t5_result%0d", i), 32'(bus.result), exp5[i]);
    end
    check("t5_index", 32'(bus.exec_index), 2);

    // Out-of-range restart index falls back to 0, then async reset mid-execution
    do_reset();
    load(3'b000, 4'd1);
    load(3'b000, 4'd1);
    load(3'b110, 4'd9);
    exec1();
    exec1();
    exec1();
    check("t6_index_wrap", 32'(bus.exec_index), 0);
    check("t6_result", 32'(bus.result), 2);
    check("t6_prev", 32'(bus.prev_result), 2);
    exec1();
    check("t6_result_next", 32'(bus.result), 3);
    check("t6_index_next", 32'(bus.exec_index), 1);
    bus.mode = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_result", 32'(bus.result), 0);
    check("t6_async_prev", 32'(bus.prev_result), 0);
    check("t6_async_count", 32'(bus.cache_count), 0);
    check("t6_async_index", 32'(bus.exec_index), 0);
    bus.mode = 1'b0;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Remaining opcodes, ending in a wrap-around overflow
    do_reset();
    load(3'b000, 4'd5);
    load(3'b001, 4'd2);
    load(3'b010, 4'd3);
    load(3'b100, 4'd0);
    load(3'b101, 4'd0);
    exec1();
    check("t7_add", 32'(bus.result), 5);
    exec1();
    check("t7_add2", 32'(bus.result), 7);
    exec1();
    check("t7_fma", 32'(bus.result), 38);
    exec1();
    check("t7_popc", 32'(bus.result), 3);
    check("t7_popc_prev", 32'(bus.prev_result), 38);
    exec1();
    check("t7_brew", 32'(bus.result), 1020);
    check("t7_brew_ovf", 32'(bus.overflow), 0);
    exec1();
    check("t7_wrap_result", 32'(bus.result), 1);
    check("t7_wrap_ovf", 32'(bus.overflow), 1);
    check("t7_wrap_index", 32'(bus.exec_index), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
